// File: rtl/veda_pkg.sv
// rtl/veda_pkg.sv - opcodes, state encoding and writeback select codes for the VEDA sequencer
package veda_pkg;

   localparam logic [5:0] OP_ADD  = 6'd0;
   localparam logic [5:0] OP_SUB  = 6'd1;
   localparam logic [5:0] OP_AND  = 6'd2;
   localparam logic [5:0] OP_OR   = 6'd3;
   localparam logic [5:0] OP_ADDI = 6'd4;
   localparam logic [5:0] OP_ANDI = 6'd5;
   localparam logic [5:0] OP_XOR  = 6'd6;
   localparam logic [5:0] OP_NOR  = 6'd7;
   localparam logic [5:0] OP_ORI  = 6'd8;
   localparam logic [5:0] OP_XORI = 6'd9;
   localparam logic [5:0] OP_SLL  = 6'd10;
   localparam logic [5:0] OP_SRL  = 6'd11;
   localparam logic [5:0] OP_LW   = 6'd12;
   localparam logic [5:0] OP_SW   = 6'd13;
   localparam logic [5:0] OP_BEQ  = 6'd14;
   localparam logic [5:0] OP_BGEZ = 6'd19;
   localparam logic [5:0] OP_J    = 6'd20;
   localparam logic [5:0] OP_JR   = 6'd21;
   localparam logic [5:0] OP_JAL  = 6'd22;
   localparam logic [5:0] OP_LUI  = 6'd23;
   localparam logic [5:0] OP_SLT  = 6'd24;
   localparam logic [5:0] OP_ILL_LO = 6'd25;
   localparam logic [5:0] OP_ILL_HI = 6'd30;
   localparam logic [5:0] OP_HALT = 6'd31;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   localparam logic [1:0] WSEL_RD  = 2'd0;
   localparam logic [1:0] WSEL_RT  = 2'd1;
   localparam logic [1:0] WSEL_R31 = 2'd2;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_DMEM = 2'd1;
   localparam logic [1:0] WB_LINK = 2'd2;
   localparam logic [1:0] WB_IMM  = 2'd3;

endpackage

// File: rtl/veda_decode.sv
// rtl/veda_decode.sv - opcode class decoder; anything not otherwise classified is treated as ALU
module veda_decode
   import veda_pkg::*;
(
   input  logic [5:0] op_i,
   output logic       is_alu_o,
   output logic       is_imm_o,
   output logic       is_lw_o,
   output logic       is_sw_o,
   output logic       is_br_o,
   output logic       is_jmp_o,
   output logic       is_halt_o,
   output logic       is_illegal_o
);

   assign is_lw_o      = (op_i == OP_LW);
   assign is_sw_o      = (op_i == OP_SW);
   assign is_br_o      = (op_i >= OP_BEQ) && (op_i <= OP_BGEZ);
   assign is_jmp_o     = (op_i >= OP_J) && (op_i <= OP_JAL);
   assign is_halt_o    = (op_i == OP_HALT);
   assign is_illegal_o = (op_i >= OP_ILL_LO) && (op_i <= OP_ILL_HI);
   // Immediate forms write rt instead of rd.
   assign is_imm_o     = (op_i == OP_ADDI) || (op_i == OP_ANDI) || (op_i == OP_ORI) ||
                         (op_i == OP_XORI) || (op_i == OP_LUI);
   assign is_alu_o     = !(is_lw_o || is_sw_o || is_br_o || is_jmp_o || is_halt_o || is_illegal_o);

endmodule

// File: rtl/veda_seq_ctrl.sv
// rtl/veda_seq_ctrl.sv - multi-cycle fetch/decode/execute sequencer owning pc, ir and retire count
module veda_seq_ctrl
   import veda_pkg::*;
#(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              branch_cond,
   input  logic [DATA_W-1:0] rs_val,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              dmem_re,
   output logic              dmem_we,
   output logic              rf_we,
   output logic [1:0]        rf_wsel,
   output logic [1:0]        wb_src,
   output logic [5:0]        alu_op,
   output logic [DATA_W-1:0] ir,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted,
   output logic              illegal,
   output logic [31:0]       retired
);

   localparam int LAT_W = $clog2(MEM_LAT + 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [31:0]       retired_q, retired_d;
   logic              illegal_q, illegal_d;

   logic [5:0]  dec_op;
   logic        is_alu, is_imm, is_lw, is_sw, is_br, is_jmp, is_halt, is_illegal;
   logic [ADDR_W-1:0] pc_inc, pc_br;
   logic        unused_rs_hi;

   // DECODE must classify the word arriving this cycle; later states use the latched ir.
   assign dec_op = (state_q == S_DECODE) ? imem_rdata[31:26] : ir_q[31:26];

   veda_decode u_decode (
      .op_i         (dec_op),
      .is_alu_o     (is_alu),
      .is_imm_o     (is_imm),
      .is_lw_o      (is_lw),
      .is_sw_o      (is_sw),
      .is_br_o      (is_br),
      .is_jmp_o     (is_jmp),
      .is_halt_o    (is_halt),
      .is_illegal_o (is_illegal)
   );

   assign pc_inc       = pc_q + ADDR_W'(1);
   assign pc_br        = pc_inc + ADDR_W'($signed(ir_q[15:0]));
   assign unused_rs_hi = ^rs_val[DATA_W-1:ADDR_W];

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      lat_d     = lat_q;
      retired_d = retired_q;
      illegal_d = illegal_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_FETCH;
         S_FETCH: begin
            if (lat_q == LAT_LAST) begin
               state_d = S_DECODE;
               lat_d   = '0;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         S_DECODE: begin
            ir_d = imem_rdata;
            if (is_halt) begin
               state_d = S_HALT;
            end else if (is_illegal) begin
               state_d   = S_HALT;
               illegal_d = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_alu) begin
               state_d = S_WB;
            end else if (is_lw || is_sw) begin
               state_d = S_MEM;
            end else if (is_br) begin
               pc_d      = branch_cond ? pc_br : pc_inc;
               state_d   = S_FETCH;
               retired_d = retired_q + 32'd1;
            end else if (is_jmp) begin
               pc_d      = (dec_op == OP_JR) ? rs_val[ADDR_W-1:0] : ir_q[ADDR_W-1:0];
               state_d   = S_FETCH;
               retired_d = retired_q + 32'd1;
            end
         end
         S_MEM: begin
            if (is_sw) begin
               pc_d      = pc_inc;
               state_d   = S_FETCH;
               retired_d = retired_q + 32'd1;
            end else if (lat_q == LAT_LAST) begin
               state_d = S_WB;
               lat_d   = '0;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         S_WB: begin
            pc_d      = pc_inc;
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         lat_q     <= '0;
         retired_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         lat_q     <= lat_d;
         retired_q <= retired_d;
         illegal_q <= illegal_d;
      end
   end

   // Strobes are gated by reset so an abandoned instruction never writes.
   assign imem_en = !reset && (state_q == S_FETCH) && (lat_q == '0);
   assign dmem_re = !reset && (state_q == S_EXEC) && is_lw;
   assign dmem_we = !reset && (state_q == S_MEM) && is_sw;
   assign rf_we   = !reset && ((state_q == S_WB) || ((state_q == S_EXEC) && (dec_op == OP_JAL)));

   always_comb begin
      rf_wsel = WSEL_RD;
      wb_src  = WB_ALU;
      if (dec_op == OP_JAL) begin
         rf_wsel = WSEL_R31;
         wb_src  = WB_LINK;
      end else if (is_lw) begin
         rf_wsel = WSEL_RT;
         wb_src  = WB_DMEM;
      end else begin
         if (is_imm) rf_wsel = WSEL_RT;
         if (dec_op == OP_LUI) wb_src = WB_IMM;
      end
   end

   assign alu_op    = (state_q == S_EXEC) ? ir_q[31:26] : 6'd0;
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
   assign halted    = (state_q == S_HALT);
   assign illegal   = illegal_q;
   assign retired   = retired_q;

endmodule

// File: tb/tb_veda_seq_ctrl.sv
// tb/tb_veda_seq_ctrl.sv - directed and randomized checks of veda_seq_ctrl at MEM_LAT 1 and 2
module tb_veda_seq_ctrl;

   localparam int NI = 2;
   localparam int AW = 9;

   typedef struct {
      int          cyc;
      logic [AW-1:0] npc;
      int          rf_n;
      int          rf_at;
      logic [1:0]  wsel;
      logic [1:0]  wsrc;
      int          dre_n;
      int          dwe_n;
      int          ret;
      int          aop_n;
      bit          halt;
      bit          ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start [NI];
   logic        branch_cond [NI];
   logic [31:0] rs_val [NI];
   wire  [31:0] imem_rdata [NI];
   wire         imem_en [NI];
   wire [AW-1:0] imem_addr [NI];
   wire         dmem_re [NI];
   wire         dmem_we [NI];
   wire         rf_we [NI];
   wire  [1:0]  rf_wsel [NI];
   wire  [1:0]  wb_src [NI];
   wire  [5:0]  alu_op [NI];
   wire  [31:0] ir [NI];
   wire [AW-1:0] pc [NI];
   wire         busy [NI];
   wire         halted [NI];
   wire         illegal [NI];
   wire  [31:0] retired [NI];

   logic [31:0] imem [NI][512];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [31:0] rd_pipe [g+1];
      always @(posedge clk) begin
         rd_pipe[0] <= imem_en[g] ? imem[g][imem_addr[g]] : 32'h7C00_0000;
         for (int i = 1; i <= g; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
      assign imem_rdata[g] = rd_pipe[g];

      veda_seq_ctrl #(.ADDR_W(AW), .DATA_W(32), .MEM_LAT(g + 1)) u_dut (
         .clk         (clk),
         .reset       (reset),
         .start       (start[g]),
         .imem_rdata  (imem_rdata[g]),
         .branch_cond (branch_cond[g]),
         .rs_val      (rs_val[g]),
         .imem_en     (imem_en[g]),
         .imem_addr   (imem_addr[g]),
         .dmem_re     (dmem_re[g]),
         .dmem_we     (dmem_we[g]),
         .rf_we       (rf_we[g]),
         .rf_wsel     (rf_wsel[g]),
         .wb_src      (wb_src[g]),
         .alu_op      (alu_op[g]),
         .ir          (ir[g]),
         .pc          (pc[g]),
         .busy        (busy[g]),
         .halted      (halted[g]),
         .illegal     (illegal[g]),
         .retired     (retired[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Per-instruction outcome from FETCH entry to the next FETCH entry (or HALT).
   function automatic exp_t model(input logic [31:0] w, input logic [AW-1:0] p, input bit bc,
                                  input logic [31:0] rsv, input int lat);
      exp_t e;
      int op;
      logic [31:0] t;
      op = int'(w[31:26]);
      e.cyc = lat + 3; e.npc = p + 1'b1; e.rf_n = 0; e.rf_at = -1; e.wsel = 2'd0; e.wsrc = 2'd0;
      e.dre_n = 0; e.dwe_n = 0; e.ret = 1; e.aop_n = (op != 0) ? 1 : 0; e.halt = 0; e.ill = 0;
      if (op >= 25) begin
         e.halt = 1; e.ill = (op != 31); e.cyc = lat + 1; e.npc = p; e.ret = 0; e.aop_n = 0;
      end else if (op == 12) begin
         e.cyc = 2 * lat + 3; e.rf_n = 1; e.rf_at = 2 * lat + 2; e.wsel = 2'd1; e.wsrc = 2'd1; e.dre_n = 1;
      end else if (op == 13) begin
         e.dwe_n = 1;
      end else if (op >= 14 && op <= 19) begin
         e.cyc = lat + 2;
         if (bc) begin
            t = 32'(p) + 32'd1 + {{16{w[15]}}, w[15:0]};
            e.npc = t[AW-1:0];
         end
      end else if (op == 20 || op == 21) begin
         e.cyc = lat + 2;
         e.npc = (op == 20) ? w[AW-1:0] : rsv[AW-1:0];
      end else if (op == 22) begin
         e.cyc = lat + 2; e.npc = w[AW-1:0]; e.rf_n = 1; e.rf_at = lat + 1; e.wsel = 2'd2; e.wsrc = 2'd2;
      end else begin
         e.rf_n = 1; e.rf_at = lat + 2;
         e.wsel = (op == 4 || op == 5 || op == 8 || op == 9 || op == 23) ? 2'd1 : 2'd0;
         e.wsrc = (op == 23) ? 2'd3 : 2'd0;
      end
      return e;
   endfunction

   // Call at the negedge of a FETCH entry cycle; returns at the next FETCH entry or HALT.
   task automatic run_one(input int k, input bit bc, input logic [31:0] rsv, output int rf_at_o);
      exp_t e;
      logic [AW-1:0] p0;
      logic [31:0] w, r0;
      logic [1:0] ws, wr;
      logic [5:0] aop;
      int cyc, rf_n, rf_at, dre, dwe, clash, aop_n;
      cyc = 0; rf_n = 0; rf_at = -1; dre = 0; dwe = 0; clash = 0; aop_n = 0;
      ws = 2'd0; wr = 2'd0; aop = 6'd0;
      branch_cond[k] = bc;
      rs_val[k] = rsv;
      p0 = pc[k];
      w = imem[k][p0];
      r0 = retired[k];
      e = model(w, p0, bc, rsv, k + 1);
      check("busy_at_fetch", busy[k], 1);
      do begin
         if (rf_we[k]) begin
            rf_n++; rf_at = cyc; ws = rf_wsel[k]; wr = wb_src[k];
            if (dmem_re[k] || imem_en[k]) clash++;
         end
         if (dmem_re[k]) dre++;
         if (dmem_we[k]) dwe++;
         if (alu_op[k] != 6'd0) begin aop_n++; aop = alu_op[k]; end
         start[k] = 1'($urandom_range(0, 1));
         @(negedge clk);
         cyc++;
      end while (!imem_en[k] && !halted[k] && cyc < 64);
      start[k] = 1'b0;
      check("latency", cyc, e.cyc);
      check("next_pc", pc[k], e.npc);
      check("ir", ir[k], w);
      check("rf_we_count", rf_n, e.rf_n);
      if (e.rf_n == 1) begin
         check("rf_we_cycle", rf_at, e.rf_at);
         check("rf_wsel", ws, e.wsel);
         check("wb_src", wr, e.wsrc);
      end
      check("dmem_re_count", dre, e.dre_n);
      check("dmem_we_count", dwe, e.dwe_n);
      check("rd_wr_same_cycle", clash, 0);
      check("alu_op_cycles", aop_n, e.aop_n);
      if (e.aop_n == 1) check("alu_op", aop, w[31:26]);
      check("retired", retired[k], r0 + e.ret);
      check("halted", halted[k], e.halt);
      check("illegal", illegal[k], e.ill);
      rf_at_o = rf_at;
   endtask

   task automatic boot(input int k);
      reset = 1'b1;
      start[0] = 1'b0;
      start[1] = 1'b0;
      repeat (2) @(negedge clk);
      check("strobes_in_reset", {imem_en[k], dmem_re[k], dmem_we[k], rf_we[k]}, 0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_strobes", {imem_en[k], dmem_re[k], dmem_we[k], rf_we[k]}, 0);
      check("rst_pc", pc[k], 0);
      check("rst_ir", ir[k], 0);
      check("rst_retired", retired[k], 0);
      check("rst_flags", {busy[k], halted[k], illegal[k]}, 0);
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
      check("fetch_after_start", imem_en[k], 1);
   endtask

   initial begin
      int rfat, seen;
      logic [31:0] r;
      logic [5:0] op;
      reset = 1'b1;
      for (int k = 0; k < NI; k++) begin
         start[k] = 1'b0; branch_cond[k] = 1'b0; rs_val[k] = 32'd0;
         for (int a = 0; a < 512; a++) imem[k][a] = 32'h7C00_0000;
      end

      imem[0][0] = 32'h0022_1800;
      boot(0);
      run_one(0, 1'b0, 32'd0, rfat);
      check("t1_rf_cycle", rfat + 1, 4);
      check("t1_pc", pc[0], 1);
      check("t1_retired", retired[0], 1);

      imem[0][0] = {6'd20, 26'd5};
      imem[0][5] = {6'd14, 5'd1, 5'd1, 16'd3};
      for (int b = 1; b >= 0; b--) begin
         boot(0);
         run_one(0, 1'b0, 32'd0, rfat);
         run_one(0, 1'(b), 32'd0, rfat);
         check("t2_branch_pc", pc[0], (b == 1) ? 9 : 6);
      end

      imem[1][0] = {6'd12, 5'd1, 5'd2, 16'd4};
      imem[1][1] = {6'd13, 5'd1, 5'd2, 16'd8};
      boot(1);
      run_one(1, 1'b0, 32'd0, rfat);
      check("t3_lw_rf_cycle", rfat + 1, 7);
      check("t3_lw_pc", pc[1], 1);
      run_one(1, 1'b0, 32'd0, rfat);
      check("t3_sw_pc", pc[1], 2);

      imem[0][0] = {6'd20, 26'd7};
      imem[0][7] = {6'd22, 26'h40};
      imem[0][64] = {6'd20, 26'd511};
      for (int v = 0; v < 2; v++) begin
         imem[0][511] = (v == 0) ? {6'd20, 26'd0} : {6'd14, 26'd0};
         boot(0);
         run_one(0, 1'b0, 32'd0, rfat);
         run_one(0, 1'b0, 32'd0, rfat);
         check("t4_jal_pc", pc[0], 64);
         run_one(0, 1'b0, 32'd0, rfat);
         check("t4_pc_511", pc[0], 511);
         run_one(0, 1'($urandom_range(0, 1)), 32'd0, rfat);
         check("t4_wrap_pc", pc[0], 0);
      end

      imem[0][0] = {6'd27, 26'd0};
      boot(0);
      run_one(0, 1'b0, 32'd0, rfat);
      check("t5_halted", halted[0], 1);
      check("t5_illegal", illegal[0], 1);
      check("t5_busy", busy[0], 0);
      seen = 0;
      start[0] = 1'b1;
      repeat (4) begin
         @(negedge clk);
         start[0] = 1'b0;
         if (imem_en[0] || dmem_re[0] || dmem_we[0] || rf_we[0] || busy[0]) seen++;
      end
      check("t5_start_ignored", seen, 0);
      check("t5_still_halted", halted[0], 1);
      check("t5_pc_hold", pc[0], 0);
      imem[0][0] = {6'd31, 26'd0};
      boot(0);
      run_one(0, 1'b0, 32'd0, rfat);
      check("t5_halt_op31", {halted[0], illegal[0]}, 2'b10);

      imem[1][0] = 32'h0022_1800;
      imem[1][1] = {6'd13, 5'd3, 5'd4, 16'd0};
      boot(1);
      run_one(1, 1'b0, 32'd0, rfat);
      repeat (3) @(negedge clk);
      check("t6_in_exec", alu_op[1], 13);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("t6_dmem_we_reset", dmem_we[1], 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("t6_dmem_we_after", dmem_we[1], 0);
      check("t6_idle", {busy[1], halted[1]}, 0);
      check("t6_pc", pc[1], 0);
      check("t6_retired", retired[1], 0);

      for (int k = 0; k < NI; k++) begin
         for (int a = 0; a < 512; a++) begin
            r = $urandom;
            op = 6'($urandom_range(0, 24));
            imem[k][a] = {op, r[25:0]};
         end
         boot(k);
         repeat (40) run_one(k, 1'($urandom_range(0, 1)), $urandom, rfat);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
